mse_accum: RTL and testbench

MSE_ACCUM -- requirements
Module: mse_accum

---
 rtl/mse_accum.sv | 123 ++++++++++++
 tb/tb_mse_accum.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mse_accum.sv
// Accumulates a stream of unsigned partial sums of squared differences into a
// saturating per-vector total and hands the total downstream with a valid/ready handshake.
`timescale 1ns/1ps
module mse_accum #(
    parameter int DATA_WIDTH_SUM = 32,
    parameter int ACC_WIDTH      = 48,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [CNT_WIDTH-1:0]      vctr_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH_SUM-1:0] in_sum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      out_acc,
    output logic                      out_sat
);

    // One extra bit above the wider operand so any overflow past the accumulator is visible.
    localparam int EXT_W = ((ACC_WIDTH > DATA_WIDTH_SUM) ? ACC_WIDTH : DATA_WIDTH_SUM) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   len;
    logic                   sat;

    logic [ACC_WIDTH-1:0]   acc_base;
    logic [EXT_W-1:0]       sum_ext;
    logic                   sum_ovf;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic [CNT_WIDTH-1:0]   len_start;
    logic [CNT_WIDTH-1:0]   len_eff;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   accept;
    logic                   release_out;

    assign in_ready    = (state != DONE);
    assign out_valid   = (state == DONE);
    assign out_acc     = out_valid ? acc : '0;
    assign out_sat     = sat;

    assign accept      = in_valid  && in_ready  && !clear;
    assign release_out = out_valid && out_ready && !clear;

    // The first word of a vector starts from zero and uses the freshly sampled length.
    always_comb begin
        acc_base  = (state == IDLE) ? '0 : acc;
        sum_ext   = EXT_W'(acc_base) + EXT_W'(in_sum);
        sum_ovf   = |sum_ext[EXT_W-1:ACC_WIDTH];
        sum_sat   = sum_ovf ? '1 : sum_ext[ACC_WIDTH-1:0];
        len_start = (vctr_len == '0) ? CNT_WIDTH'(1) : vctr_len;
        len_eff   = (state == IDLE) ? len_start : len;
        cnt_next  = (state == IDLE) ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        next_state = (cnt_next == len_eff) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Saturation is sticky for the whole vector and only drops once the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            len <= CNT_WIDTH'(1);
            sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            acc <= sum_sat;
            cnt <= cnt_next;
            if (state == IDLE) begin
                len <= len_start;
                sat <= sum_ovf;
            end else begin
                sat <= sat | sum_ovf;
            end
        end else if (release_out) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mse_accum.sv
// Directed bench for mse_accum: stimulus pushes expected totals into a scoreboard that a
// separate monitor drains on every output handshake.
`timescale 1ns/1ps
module tb_mse_accum;

    localparam int DW = 32;
    localparam int AW = 34;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [CW-1:0] vctr_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sum;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_sat;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mse_accum #(
        .DATA_WIDTH_SUM(DW),
        .ACC_WIDTH     (AW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .vctr_len (vctr_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectResult(input logic [AW-1:0] a, input logic s);
        exp_t e;
        e.acc = a;
        e.sat = s;
        sb.push_back(e);
    endtask

    // Present one word and hold it until the block takes it, giving up after a bounded wait.
    task automatic applyStimulus(input logic [DW-1:0] s, input logic [CW-1:0] len);
        bit taken;
        taken    = 1'b0;
        vctr_len = len;
        in_sum   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (in_ready) taken = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: word 0x%0h never accepted, in_ready=%0b", s, in_ready);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a result counts as consumed only when clear and reset are both low.
    always @(negedge clk) begin
        if (!out_valid) begin
            checkOutput("acc_zero_when_invalid", 64'(out_acc), 64'd0);
        end else if (out_ready && !clear && !rst) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_result: got acc 0x%0h sat %0b, expected no result", out_acc, out_sat);
            end else begin
                popped = sb.pop_front();
                checkOutput("result_acc", 64'(out_acc), 64'(popped.acc));
                checkOutput("result_sat", 64'(out_sat), 64'(popped.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        vctr_len  = 8'd1;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset_out_acc",   64'(out_acc),   64'd0);
        checkOutput("reset_out_sat",   64'(out_sat),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Basic four-word vector, one-cycle latency
        expectResult(34'd100, 1'b0);
        applyStimulus(32'd10, 8'd4);
        applyStimulus(32'd20, 8'd4);
        applyStimulus(32'd30, 8'd4);
        applyStimulus(32'd40, 8'd4);
        checkOutput("basic_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("basic_in_ready_low",  64'(in_ready),  64'd0);
        idleCycles(1);
        checkOutput("basic_single_cycle",  64'(out_valid), 64'd0);

        // Backpressure holds the result
        out_ready = 1'b0;
        expectResult(34'd12, 1'b0);
        applyStimulus(32'd5, 8'd2);
        applyStimulus(32'd7, 8'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_out_acc",   64'(out_acc),   64'd12);
            checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
            idleCycles(1);
        end
        out_ready = 1'b1;
        idleCycles(1);
        checkOutput("bp_in_ready_after", 64'(in_ready),  64'd1);
        checkOutput("bp_valid_after",    64'(out_valid), 64'd0);

        // Gaps between words; vctr_len changes mid-vector must be ignored
        expectResult(34'd6, 1'b0);
        applyStimulus(32'd1, 8'd3);
        vctr_len = 8'd1;
        idleCycles(2);
        applyStimulus(32'd2, 8'd5);
        idleCycles(2);
        applyStimulus(32'd3, 8'd1);
        checkOutput("gap_done_valid", 64'(out_valid), 64'd1);
        idleCycles(1);

        // Zero length behaves as length one
        expectResult(34'd9, 1'b0);
        applyStimulus(32'd9, 8'd0);
        checkOutput("len0_done_valid", 64'(out_valid), 64'd1);
        idleCycles(1);

        // Saturation: 8 x 0xFFFFFFFF exceeds 34 bits
        expectResult(34'h3_FFFF_FFFF, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(32'hFFFF_FFFF, 8'd8);
        checkOutput("sat_flag_set", 64'(out_sat), 64'd1);
        idleCycles(1);
        checkOutput("sat_flag_cleared", 64'(out_sat), 64'd0);

        // Clear after two of four words, with a word presented in the same cycle
        applyStimulus(32'd50, 8'd4);
        applyStimulus(32'd60, 8'd4);
        in_sum   = 32'd77;
        in_valid = 1'b1;
        clear    = 1'b1;
        idleCycles(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear_accum_valid", 64'(out_valid), 64'd0);
        expectResult(34'd4, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'd1, 8'd4);
        idleCycles(1);

        // Clear in DONE wins over the output handshake; result is dropped
        out_ready = 1'b0;
        applyStimulus(32'd3, 8'd2);
        applyStimulus(32'd3, 8'd2);
        checkOutput("done_valid_before_clear", 64'(out_valid), 64'd1);
        checkOutput("done_acc_before_clear",   64'(out_acc),   64'd6);
        clear     = 1'b1;
        out_ready = 1'b1;
        idleCycles(1);
        clear     = 1'b0;
        checkOutput("clear_done_valid",    64'(out_valid), 64'd0);
        checkOutput("clear_done_in_ready", 64'(in_ready),  64'd1);

        // Async reset while a result is pending, between clock edges
        out_ready = 1'b0;
        applyStimulus(32'd8, 8'd2);
        applyStimulus(32'd8, 8'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("async_rst_out_acc",   64'(out_acc),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Async reset mid-vector discards the partial total
        applyStimulus(32'd100, 8'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        expectResult(34'd4, 1'b0);
        applyStimulus(32'd2, 8'd2);
        applyStimulus(32'd2, 8'd2);
        idleCycles(3);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
